// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types, defaults and the round-robin selection helper for the UART TX arbiter.
// rr_pick searches from rr_ptr upward (mod n) and returns the first requester with valid set.
package uart_arb_pkg;

    typedef enum logic {
        IDLE,
        XFER
    } arb_state_t;

    localparam int NUM_REQ_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam int MAX_REQ         = 8;
    localparam int PTR_W           = 3;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then map back to a port index.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid_vec,
        input logic [PTR_W-1:0]   rr_ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] rot;
        int                 idx;
        rot     = '0;
        rr_pick = rr_ptr;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && idx < MAX_REQ) rot[k] = valid_vec[idx];
        end
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = int'(rr_ptr) + k;
                if (idx >= n) idx = idx - n;
                rr_pick = PTR_W'(idx);
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]        REQ_LAST;
    logic [NUM_REQ-1:0]        REQ_READY;
    logic                      TX_VALID;
    logic [DATA_W-1:0]         TX_DATA;
    logic                      TX_READY;
    logic [ID_W-1:0]           GRANT_ID;
    logic                      BUSY;
    logic                      TIMEOUT_PULSE;
    logic [ID_W-1:0]           TIMEOUT_ID;

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
        output REQ_READY, TX_VALID, TX_DATA, GRANT_ID, BUSY, TIMEOUT_PULSE, TIMEOUT_ID
    );

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
        input  REQ_READY, TX_VALID, TX_DATA, GRANT_ID, BUSY, TIMEOUT_PULSE, TIMEOUT_ID
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
// Reusable by any fabric arbiter with up to MAX_REQ requesters.
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         i_valid,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [PTR_W-1:0]   w_ptr_ext;
    logic [PTR_W-1:0]   w_pick;

    assign w_valid_ext = MAX_REQ'(i_valid);
    assign w_ptr_ext   = PTR_W'(i_ptr);
    assign w_pick      = rr_pick(w_valid_ext, w_ptr_ext, NUM_REQ);
    assign o_idx       = ID_W'(w_pick);
    assign o_any       = |i_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte path among NUM_REQ sources,
// with a watchdog that aborts a packet whose owner stops supplying bytes.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic              FAB_CLK,
    input logic              FAB_RESET,
    uart_tx_arbiter_if.slave bus
);
    localparam int               ID_W       = $clog2(NUM_REQ);
    localparam int               CNT_W      = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);

    arb_state_t         r_state, w_next_state;
    logic [ID_W-1:0]    r_grant, w_next_grant;
    logic [ID_W-1:0]    r_rr, w_next_rr;
    logic [ID_W-1:0]    r_tmo_id, w_next_tmo_id;
    logic [CNT_W-1:0]   r_wdog, w_next_wdog;
    logic               r_tmo_pulse, w_next_tmo_pulse;
    logic [ID_W-1:0]    w_pick, w_grant_inc;
    logic               w_any, w_sel_valid, w_sel_last, w_xfer;
    logic               w_tx_valid;
    logic [NUM_REQ-1:0] w_req_ready;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_valid (bus.REQ_VALID),
        .i_ptr   (r_rr),
        .o_idx   (w_pick),
        .o_any   (w_any)
    );

    assign w_sel_valid = bus.REQ_VALID[r_grant];
    assign w_sel_last  = bus.REQ_LAST[r_grant];
    assign w_xfer      = (r_state == XFER) && w_sel_valid && bus.TX_READY;
    assign w_grant_inc = (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;

    // Backpressure with data pending leaves the watchdog untouched; only an absent owner counts.
    always_comb begin
        w_next_state     = r_state;
        w_next_grant     = r_grant;
        w_next_rr        = r_rr;
        w_next_wdog      = r_wdog;
        w_next_tmo_id    = r_tmo_id;
        w_next_tmo_pulse = 1'b0;
        w_tx_valid       = 1'b0;
        w_req_ready      = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_grant = w_pick;
                    w_next_wdog  = '0;
                    w_next_state = XFER;
                end
            end
            XFER: begin
                w_tx_valid           = w_sel_valid;
                w_req_ready[r_grant] = bus.TX_READY;
                if (w_xfer) begin
                    w_next_wdog = '0;
                    if (w_sel_last) begin
                        w_next_rr    = w_grant_inc;
                        w_next_state = IDLE;
                    end
                end else if (!w_sel_valid) begin
                    if (r_wdog == WDOG_LIMIT) begin
                        w_next_tmo_pulse = 1'b1;
                        w_next_tmo_id    = r_grant;
                        w_next_rr        = w_grant_inc;
                        w_next_wdog      = '0;
                        w_next_state     = IDLE;
                    end else begin
                        w_next_wdog = r_wdog + 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr        <= '0;
            r_wdog      <= '0;
            r_tmo_id    <= '0;
            r_tmo_pulse <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_grant     <= w_next_grant;
            r_rr        <= w_next_rr;
            r_wdog      <= w_next_wdog;
            r_tmo_id    <= w_next_tmo_id;
            r_tmo_pulse <= w_next_tmo_pulse;
        end
    end

    assign bus.TX_VALID      = w_tx_valid;
    assign bus.TX_DATA       = bus.REQ_DATA[int'(r_grant)*DATA_W +: DATA_W];
    assign bus.REQ_READY     = w_req_ready;
    assign bus.GRANT_ID      = r_grant;
    assign bus.BUSY          = (r_state == XFER);
    assign bus.TIMEOUT_PULSE = r_tmo_pulse;
    assign bus.TIMEOUT_ID    = r_tmo_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a packet-level ownership model of the arbiter.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 16;

    typedef logic [8:0] byte_q_t[$];

    logic FAB_CLK   = 1'b0;
    logic FAB_RESET = 1'b1;

    always #5 FAB_CLK = ~FAB_CLK;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .FAB_CLK   (FAB_CLK),
        .FAB_RESET (FAB_RESET),
        .bus       (bus)
    );

    int            nChecks = 0;
    int            nErrors = 0;
    byte_q_t       srcQ [NREQ];
    logic [10:0]   txLog[$];
    logic [NREQ-1:0] stallMask;
    logic          txReadyDrv;
    int            modeSel [NREQ];
    int            cycleIdx, busyCycles, firstTxCycle, pulseCount, pulseCycle;
    logic [1:0]    pulseId;
    logic          pulseBusy, obsBusy;
    logic [NREQ-1:0] obsReqReady;

    // Reference model: who owns the path, where the next search starts, and how long the owner has been silent.
    int mOwner, mRr, mGrant, mStarve, mTmoId;
    bit mPulse;

    task automatic modelReset();
        mOwner = -1; mRr = 0; mGrant = 0; mStarve = 0; mTmoId = 0; mPulse = 0;
    endtask

    task automatic modelAdvance(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic rdy);
        int c;
        mPulse = 0;
        if (mOwner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (mRr + k) % NREQ;
                if (mOwner < 0 && v[c]) begin
                    mOwner = c; mGrant = c; mStarve = 0;
                end
            end
        end else if (v[mOwner] && rdy) begin
            mStarve = 0;
            if (l[mOwner]) begin
                mRr = (mOwner + 1) % NREQ; mOwner = -1;
            end
        end else if (!v[mOwner]) begin
            mStarve++;
            if (mStarve >= TMO) begin
                mPulse = 1; mTmoId = mOwner; mRr = (mOwner + 1) % NREQ; mOwner = -1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] mkEntry(input int id, input bit last, input int data);
        return {2'(id), last, 8'(data)};
    endfunction

    function automatic logic [10:0] logEntry(input int k);
        if (k < txLog.size()) return txLog[k];
        return 11'h7ff;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < NREQ; i++) if (srcQ[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic startTest();
        txLog.delete();
        cycleIdx = 0; busyCycles = 0; firstTxCycle = -1;
        pulseCount = 0; pulseCycle = -1; pulseId = 2'd0; pulseBusy = 1'b1;
    endtask

    // One clock: drive from the source queues, compare the whole output set, then let the model step.
    task automatic applyStimulus();
        logic [NREQ-1:0]    v, l, eReady;
        logic [NREQ*DW-1:0] d;
        logic [8:0]         head;
        logic [18:0]        expVec, obsVec;
        logic               eBusy, eTxValid;
        logic [7:0]         eData;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (srcQ[i].size() > 0) begin
                head = srcQ[i][0];
                v[i] = ~stallMask[i];
                l[i] = head[8];
                d[i*DW +: DW] = head[7:0];
            end
        end
        bus.REQ_VALID = v; bus.REQ_DATA = d; bus.REQ_LAST = l; bus.TX_READY = txReadyDrv;
        #1;
        eBusy = (mOwner >= 0); eTxValid = 1'b0; eData = 8'h00; eReady = '0;
        if (eBusy) begin
            eTxValid = v[mOwner];
            eData    = eTxValid ? d[mOwner*DW +: DW] : 8'h00;
            eReady   = txReadyDrv ? NREQ'(1 << mOwner) : '0;
        end
        expVec = {eBusy, eTxValid, eData, eReady, 2'(mGrant), mPulse, 2'(mTmoId)};
        obsVec = {bus.BUSY, bus.TX_VALID, eTxValid ? bus.TX_DATA : 8'h00, bus.REQ_READY,
                  bus.GRANT_ID, bus.TIMEOUT_PULSE, bus.TIMEOUT_ID};
        checkOutput("cycle", 32'(obsVec), 32'(expVec));
        obsBusy = bus.BUSY; obsReqReady = bus.REQ_READY;
        if (bus.BUSY) busyCycles++;
        if (bus.TX_VALID && bus.TX_READY) begin
            if (txLog.size() == 0) firstTxCycle = cycleIdx;
            txLog.push_back({bus.GRANT_ID, l[bus.GRANT_ID], bus.TX_DATA});
        end
        if (bus.TIMEOUT_PULSE) begin
            pulseCount++; pulseCycle = cycleIdx; pulseId = bus.TIMEOUT_ID; pulseBusy = bus.BUSY;
        end
        for (int i = 0; i < NREQ; i++) if (v[i] && bus.REQ_READY[i]) void'(srcQ[i].pop_front());
        modelAdvance(v, l, txReadyDrv);
        cycleIdx++;
        @(negedge FAB_CLK);
    endtask

    task automatic runUntilIdle(input string tag, input int maxCycles);
        logic drained;
        drained = 1'b0;
        for (int n = 0; n < maxCycles && !drained; n++) begin
            applyStimulus();
            drained = !obsBusy && allEmpty();
        end
        checkOutput(tag, 32'(drained), 32'd1);
    endtask

    task automatic resetDut();
        FAB_RESET = 1'b1;
        bus.REQ_VALID = '1; bus.REQ_DATA = '1; bus.REQ_LAST = '1; bus.TX_READY = 1'b1;
        #1;
        checkOutput("resetOutputs", 32'({bus.TX_VALID, bus.REQ_READY, bus.BUSY, bus.GRANT_ID,
                                         bus.TIMEOUT_PULSE, bus.TIMEOUT_ID}), 32'd0);
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        FAB_RESET = 1'b0;
        modelReset();
        for (int i = 0; i < NREQ; i++) srcQ[i].delete();
        stallMask = '0; txReadyDrv = 1'b1;
        startTest();
    endtask

    task automatic pushRandomPacket(input int i);
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) srcQ[i].push_back({k == len - 1, 8'($urandom)});
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        stallMask = '0; txReadyDrv = 1'b1;
        modelReset();
        resetDut();

        // Single requester, three bytes.
        srcQ[1].push_back({1'b0, 8'h41});
        srcQ[1].push_back({1'b0, 8'h42});
        srcQ[1].push_back({1'b1, 8'h43});
        runUntilIdle("t1Drain", 20);
        checkOutput("t1Count", txLog.size(), 3);
        for (int k = 0; k < 3; k++) checkOutput("t1Byte", logEntry(k), mkEntry(1, k == 2, 8'h41 + k));
        checkOutput("t1Busy", busyCycles, 3);
        checkOutput("t1Latency", firstTxCycle, 1);
        checkOutput("t1Grant", bus.GRANT_ID, 1);

        // Four simultaneous two-byte packets, twice, to exercise the pointer wrap.
        resetDut();
        for (int round = 0; round < 2; round++) begin
            startTest();
            for (int i = 0; i < NREQ; i++) begin
                srcQ[i].push_back({1'b0, 8'(i * 16 + 1)});
                srcQ[i].push_back({1'b1, 8'(i * 16 + 2)});
            end
            runUntilIdle("t2Drain", 40);
            checkOutput("t2Count", txLog.size(), 8);
            for (int k = 0; k < 8; k++)
                checkOutput("t2Order", logEntry(k), mkEntry(k / 2, (k % 2) == 1, (k / 2) * 16 + (k % 2) + 1));
        end

        // Long UART backpressure must never look like starvation.
        startTest();
        txReadyDrv = 1'b0;
        srcQ[2].push_back({1'b1, 8'h77});
        repeat (2001) applyStimulus();
        checkOutput("t3NoPulse", pulseCount, 0);
        checkOutput("t3Stalled", txLog.size(), 0);
        txReadyDrv = 1'b1;
        applyStimulus();
        checkOutput("t3Ready", obsReqReady, 4'b0100);
        checkOutput("t3Byte", logEntry(0), mkEntry(2, 1, 8'h77));
        runUntilIdle("t3Drain", 5);

        // Owner goes silent mid-packet; a waiting requester takes over after the abort.
        startTest();
        srcQ[3].push_back({1'b0, 8'h33});
        srcQ[0].push_back({1'b1, 8'h0A});
        runUntilIdle("t4Drain", 40);
        checkOutput("t4PulseCount", pulseCount, 1);
        checkOutput("t4PulseCycle", pulseCycle, 18);
        checkOutput("t4TimeoutId", pulseId, 3);
        checkOutput("t4BusyAtPulse", pulseBusy, 0);
        checkOutput("t4FirstByte", logEntry(0), mkEntry(3, 0, 8'h33));
        checkOutput("t4NextGrant", logEntry(1), mkEntry(0, 1, 8'h0A));

        // Asynchronous reset in the middle of a five-byte packet.
        startTest();
        for (int k = 0; k < 5; k++) srcQ[1].push_back({k == 4, 8'(8'h51 + k)});
        repeat (3) applyStimulus();
        checkOutput("t5Progress", txLog.size(), 2);
        bus.REQ_VALID = 4'b0010; bus.REQ_DATA = '0; bus.REQ_DATA[15:8] = 8'h53;
        bus.REQ_LAST = '0; bus.TX_READY = 1'b1;
        #1;
        checkOutput("t5PreReset", {bus.TX_VALID, bus.TX_DATA}, {1'b1, 8'h53});
        #1 FAB_RESET = 1'b1;
        #1;
        checkOutput("t5AsyncReset", {bus.TX_VALID, bus.REQ_READY, bus.BUSY, bus.GRANT_ID}, 8'h00);
        @(negedge FAB_CLK);
        FAB_RESET = 1'b0;
        modelReset();
        for (int i = 0; i < NREQ; i++) srcQ[i].delete();
        startTest();
        for (int k = 0; k < 5; k++) srcQ[1].push_back({k == 4, 8'(8'h51 + k)});
        runUntilIdle("t5Drain", 20);
        checkOutput("t5Count", txLog.size(), 5);
        for (int k = 0; k < 5; k++) checkOutput("t5Byte", logEntry(k), mkEntry(1, k == 4, 8'h51 + k));

        // Randomized traffic with per-block source behaviour: steady, bursty or silent long enough to time out.
        startTest();
        for (int blk = 0; blk < 60; blk++) begin
            for (int i = 0; i < NREQ; i++) modeSel[i] = $urandom_range(0, 2);
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (srcQ[i].size() == 0 && $urandom_range(0, 3) == 0) pushRandomPacket(i);
                    case (modeSel[i])
                        0:       stallMask[i] = ($urandom_range(0, 9) == 0);
                        1:       stallMask[i] = ($urandom_range(0, 1) == 1);
                        default: stallMask[i] = 1'b1;
                    endcase
                end
                txReadyDrv = ($urandom_range(0, 3) != 0);
                applyStimulus();
            end
        end
        stallMask = '0; txReadyDrv = 1'b1;
        runUntilIdle("randDrain", 400);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
